mem_store_capture: RTL and testbench
====================================

# mem_store_capture

Snoops the CPU/memory store bus of the 8-bit multicycle MIPS system (`memwrite`, `adr`, `writedata`) and captures every store that falls inside a configured address window into a small FIFO. A downstream consumer (UART or LED/7-seg driver) drains the FIFO through a valid/ready handshake. The block sits directly downstream of `mipscpu_mem`, in parallel with the data memory. It lets the Fibonacci result stores (addresses 128–141) be observed on hardware as well as in simulation.

## Interface
- `ADDR_BASE`, 8'd128: first captured address (inclusive).
- `ADDR_LAST`, 8'd141: last captured address (inclusive); a store here also sets `done`.
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥2.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `memwrite`  in  1  CPU store strobe, one cycle per store.
- `adr`  in  8  store address.
- `writedata`  in  8  store data.
- `out_valid`  out  1  FIFO head entry is valid.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_adr`  out  8  head entry address.
- `out_data`  out  8  head entry data.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: a qualifying store was dropped.
- `done`  out  1  sticky: a store to `ADDR_LAST` was captured.
- `fib_ok`, `fib_err`  out  1 each  present only with `FIB_CHECK_EN`.
- `err_adr`  out  8  present only with `FIB_CHECK_EN`.

## Operation
- A store qualifies when `memwrite` is high and `ADDR_BASE ≤ adr ≤ ADDR_LAST` (unsigned compare). The block samples the bus on the rising edge of `clk`.
- Push: a qualifying store writes `{adr, writedata}` at the write pointer when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Drop: a qualifying store while full with no pop is discarded and sets `overflow`. `overflow` stays set until reset.
- Pop: occurs when `out_valid && out_ready`. `out_valid` is high exactly when `level != 0`. `out_ready` is ignored while `out_valid` is low.
- Head output: `out_adr`/`out_data` are read asynchronously from the head slot. They are stable while `out_valid` is high and the consumer has not popped.
- `level` tracks occupancy:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- Pointers are $clog2(DEPTH) bits and wrap modulo `DEPTH`.
- `done` is set on the edge that captures a store to `ADDR_LAST`. It is not set when that store is dropped.
- Non-qualifying stores have no effect.

## Timing
- Reset values:
  - `out_valid`=0, `level`=0, `overflow`=0, `done`=0
  - `out_adr`/`out_data` = 0 (the array is not cleared; outputs are masked to 0 while empty)
  - `fib_ok`=0, `fib_err`=0, `err_adr`=0
- Latency: a store sampled at edge N appears with `out_valid`=1 in the cycle after edge N.
- Throughput: one push and one pop per cycle.
- Reset mid-operation: on the reset edge, pointers, `level` and all flags return to reset values. Queued entries are lost, and any store sampled on that same edge is ignored.
- Simultaneous full + push + pop: the push is accepted and `overflow` does not set.

## Configuration
- Macro: `MEM_CAPTURE_FIB_CHECK_EN`.
- Defined: the block adds an in-line Fibonacci checker with registers `exp_a`=0, `exp_b`=1, `exp_adr`=`ADDR_BASE`.
  - Each accepted push is compared against them.
  - Match (`adr==exp_adr` and `writedata==exp_a`): `exp_a←exp_b`, `exp_b←exp_a+exp_b` (8-bit, wraps), `exp_adr←exp_adr+1`.
  - Mismatch: `fib_err` is set (sticky), and `err_adr` latches the address of the first mismatch only.
  - `fib_ok` = `done && !fib_err`.
- Undefined: the checker registers and ports `fib_ok`, `fib_err`, `err_adr` are absent. FIFO behaviour is identical.

## Structure
- Package `mem_capture_pkg` holds:
  - the default window constants `CAP_ADDR_BASE`/`CAP_ADDR_LAST`
  - `CAP_DEPTH`
  - the entry typedef `cap_entry_t` (`adr[7:0]`, `data[7:0]`)
- Sub-module `sync_fifo`: parameterised storage, pointers and level logic. The top level holds window decode, the sticky flags and the optional checker.

## Test plan
- Reset, then 14 stores to 128..141 with data 0,1,1,2,…,233 and `out_ready`=1 → 14 pops in order. Final flags: `done`=1, `overflow`=0, `level`=0; with the macro, `fib_ok`=1.
- Stores to 127, 142 and 0, plus a read cycle with `memwrite`=0 at 130 → `level` stays 0, `out_valid` stays 0.
- `out_ready`=0 and 17 qualifying stores with `DEPTH`=16 → `level`=16, `overflow`=1; the 17th entry is absent on drain.
- FIFO full, then in one cycle `out_ready`=1 plus a store (135, 8'h0D) → `level` stays 16, `overflow`=0, and the entry appears last.
- Macro defined, store (131, 8'd3) in place of 2 → `fib_err`=1, `err_adr`=131, `fib_ok`=0 after the store to 141.
- Assert `reset` for one cycle with 5 entries queued → next cycle `level`=0, `out_valid`=0, `done`=0, `overflow`=0.

Source files
------------

// File: rtl/mem_capture_pkg.sv
// mem_capture_pkg: shared constants and entry type for the store-capture block.
// Default window covers the Fibonacci result stores at 128..141.
package mem_capture_pkg;
    localparam logic [7:0] CAP_ADDR_BASE = 8'd128;
    localparam logic [7:0] CAP_ADDR_LAST = 8'd141;
    localparam int CAP_DEPTH = 16;
    typedef struct packed {
        logic [7:0] adr;
        logic [7:0] data;
    } cap_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of cap_entry_t with occupancy level.
// Head is read combinationally and masked to zero while empty.
module sync_fifo
    import mem_capture_pkg::*;
#(
    parameter int DEPTH = CAP_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_req,
    input  logic                     pop_req,
    input  cap_entry_t               wr_entry,
    output cap_entry_t               rd_entry,
    output logic                     valid,
    output logic                     push_ok,
    output logic                     pop_ok,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    cap_entry_t mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic full;

    assign valid    = level_q != '0;
    assign full     = level_q == FULL_LEVEL;
    assign pop_ok   = valid && pop_req;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok  = push_req && (!full || pop_ok);
    assign rd_entry = valid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = (push_ok && !pop_ok) ? level_q + (AW + 1)'(1) :
                   (pop_ok && !push_ok) ? level_q - (AW + 1)'(1) : level_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_entry;
    end
endmodule

// File: rtl/mem_store_capture.sv
// mem_store_capture: captures CPU stores inside [ADDR_BASE, ADDR_LAST] into a FIFO.
// Optional Fibonacci checker enabled by defining MEM_CAPTURE_FIB_CHECK_EN.
module mem_store_capture
    import mem_capture_pkg::*;
#(
    parameter logic [7:0] ADDR_BASE = CAP_ADDR_BASE,
    parameter logic [7:0] ADDR_LAST = CAP_ADDR_LAST,
    parameter int         DEPTH     = CAP_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    memwrite,
    input  logic [7:0]              adr,
    input  logic [7:0]              writedata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_adr,
    output logic [7:0]              out_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    done
`ifdef MEM_CAPTURE_FIB_CHECK_EN
    ,
    output logic                    fib_ok,
    output logic                    fib_err,
    output logic [7:0]              err_adr
`endif
);
    logic qual, push_ok, pop_ok;
    logic overflow_q, overflow_d, done_q, done_d;
    cap_entry_t wr_entry, rd_entry;

    assign qual     = memwrite && adr >= ADDR_BASE && adr <= ADDR_LAST;
    assign wr_entry = '{adr: adr, data: writedata};

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_req (qual),
        .pop_req  (out_ready),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry),
        .valid    (out_valid),
        .push_ok  (push_ok),
        .pop_ok   (pop_ok),
        .level    (level)
    );

    assign out_adr  = rd_entry.adr;
    assign out_data = rd_entry.data;
    assign overflow = overflow_q;
    assign done     = done_q;

    always_comb begin
        overflow_d = overflow_q || (qual && !push_ok);
        done_d     = done_q || (push_ok && adr == ADDR_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

`ifdef MEM_CAPTURE_FIB_CHECK_EN
    logic [7:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d, exp_adr_q, exp_adr_d, err_adr_q, err_adr_d;
    logic fib_err_q, fib_err_d, match;

    assign match = adr == exp_adr_q && writedata == exp_a_q;

    // Expectations advance only on a matching push; err_adr keeps the first miss.
    always_comb begin
        exp_a_d   = (push_ok && match) ? exp_b_q : exp_a_q;
        exp_b_d   = (push_ok && match) ? exp_a_q + exp_b_q : exp_b_q;
        exp_adr_d = (push_ok && match) ? exp_adr_q + 8'd1 : exp_adr_q;
        fib_err_d = fib_err_q || (push_ok && !match);
        err_adr_d = (push_ok && !match && !fib_err_q) ? adr : err_adr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_a_q   <= 8'd0;
            exp_b_q   <= 8'd1;
            exp_adr_q <= ADDR_BASE;
            fib_err_q <= 1'b0;
            err_adr_q <= 8'd0;
        end else begin
            exp_a_q   <= exp_a_d;
            exp_b_q   <= exp_b_d;
            exp_adr_q <= exp_adr_d;
            fib_err_q <= fib_err_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign fib_ok  = done_q && !fib_err_q;
    assign fib_err = fib_err_q;
    assign err_adr = err_adr_q;
`endif
endmodule

// File: tb/tb_mem_store_capture.sv
// tb_mem_store_capture: directed self-checking bench for mem_store_capture.
module tb_mem_store_capture;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic memwrite = 1'b0;
    logic [7:0] adr = 8'd0;
    logic [7:0] writedata = 8'd0;
    logic out_ready = 1'b0;
    logic out_valid, overflow, done;
    logic [7:0] out_adr, out_data;
    logic [4:0] level;
`ifdef MEM_CAPTURE_FIB_CHECK_EN
    logic fib_ok, fib_err;
    logic [7:0] err_adr;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_store_capture dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .adr       (adr),
        .writedata (writedata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_adr   (out_adr),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow),
        .done      (done)
`ifdef MEM_CAPTURE_FIB_CHECK_EN
        ,
        .fib_ok    (fib_ok),
        .fib_err   (fib_err),
        .err_adr   (err_adr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic mw, input logic [7:0] a, input logic [7:0] d, input logic rdy);
        memwrite = mw;
        adr = a;
        writedata = d;
        out_ready = rdy;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 8'd0, 8'd0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] fa, fb, ft, ea, ed;
        #1;
        step(1'b0, 8'd0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 8'd0, 1'b0);
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_done", done, 0);
        chk("rst_adr", out_adr, 0);
        chk("rst_data", out_data, 0);
`ifdef MEM_CAPTURE_FIB_CHECK_EN
        chk("rst_fib_ok", fib_ok, 0);
        chk("rst_fib_err", fib_err, 0);
        chk("rst_err_adr", err_adr, 0);
`endif

        // Fibonacci stream, consumer always ready: each entry popped the cycle after capture.
        fa = 8'd0;
        fb = 8'd1;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 8'(128 + i), fa, 1'b1);
            chk("fib_valid", out_valid, 1);
            chk("fib_adr", out_adr, 128 + i);
            chk("fib_data", out_data, fa);
            chk("fib_level", level, 1);
            ft = fa + fb;
            fa = fb;
            fb = ft;
        end
        step(1'b0, 8'd0, 8'd0, 1'b1);
        chk("fib_end_level", level, 0);
        chk("fib_end_valid", out_valid, 0);
        chk("fib_done", done, 1);
        chk("fib_overflow", overflow, 0);
`ifdef MEM_CAPTURE_FIB_CHECK_EN
        chk("fib_ok", fib_ok, 1);
`endif

        // Stores outside the window and a non-write cycle are ignored.
        step(1'b1, 8'd127, 8'hAA, 1'b0);
        chk("nq127_level", level, 0);
        step(1'b1, 8'd142, 8'hBB, 1'b0);
        chk("nq142_level", level, 0);
        step(1'b1, 8'd0, 8'hCC, 1'b0);
        chk("nq0_level", level, 0);
        step(1'b0, 8'd130, 8'hDD, 1'b0);
        chk("nqrd_level", level, 0);
        chk("nq_valid", out_valid, 0);

        // Fill to full, then push+pop while full, then drop one store.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(128 + i % 14), 8'(8'h40 + i), 1'b0);
        chk("full_level", level, 16);
        chk("full_overflow", overflow, 0);
        chk("full_head_adr", out_adr, 128);
        chk("full_head_data", out_data, 8'h40);
        step(1'b1, 8'd135, 8'h0D, 1'b1);
        chk("fpp_level", level, 16);
        chk("fpp_overflow", overflow, 0);
        chk("fpp_head_adr", out_adr, 129);
        chk("fpp_head_data", out_data, 8'h41);
        step(1'b1, 8'd129, 8'hEE, 1'b0);
        chk("drop_level", level, 16);
        chk("drop_overflow", overflow, 1);
        for (int k = 0; k < 16; k++) begin
            ea = (k < 15) ? 8'(128 + (k + 1) % 14) : 8'd135;
            ed = (k < 15) ? 8'(8'h41 + k) : 8'h0D;
            chk("drain_valid", out_valid, 1);
            chk("drain_adr", out_adr, ea);
            chk("drain_data", out_data, ed);
            step(1'b0, 8'd0, 8'd0, 1'b1);
        end
        chk("drain_level", level, 0);
        chk("drain_valid_end", out_valid, 0);
        chk("drain_adr_mask", out_adr, 0);
        chk("drain_data_mask", out_data, 0);
        chk("drain_overflow_sticky", overflow, 1);
        chk("drain_done", done, 1);

        // Reset with 5 queued entries and a store on the reset edge.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(128 + i), 8'(i), 1'b0);
        chk("pre_rst_level", level, 5);
        reset = 1'b1;
        step(1'b1, 8'd130, 8'h55, 1'b0);
        reset = 1'b0;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_overflow", overflow, 0);
        step(1'b0, 8'd0, 8'd0, 1'b0);
        chk("post_rst_level", level, 0);

`ifdef MEM_CAPTURE_FIB_CHECK_EN
        // Corrupted sequence: 131 carries 3 instead of 2.
        do_reset();
        fa = 8'd0;
        fb = 8'd1;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 8'(128 + i), (i == 3) ? 8'd3 : fa, 1'b1);
            ft = fa + fb;
            fa = fb;
            fb = ft;
        end
        chk("bad_fib_err", fib_err, 1);
        chk("bad_err_adr", err_adr, 131);
        chk("bad_fib_ok", fib_ok, 0);
        chk("bad_done", done, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
